// File: rtl/hamming_stream_acc.sv
// hamming_stream_acc
//
// Streams two N-bit operands in as CC chunks of W = N/CC bits each (LSB
// chunk first). It accumulates the Hamming distance between them across one
// frame, then holds the result with a threshold compare until the next frame
// starts.
//
// Ports:
//   clk       - single clock; all state changes on the rising edge
//   rst       - synchronous, active-low reset (0 = reset)
//   start     - one-cycle pulse that opens a frame (honoured in IDLE and DONE)
//   in_valid  - a g/e chunk is present this cycle
//   in_ready  - block accepts a chunk this cycle (high throughout ACCUM)
//   g_input   - garbler chunk, W bits
//   e_input   - evaluator chunk, W bits, same beat order as g_input
//   thresh    - compare threshold, sampled on the edge that enters DONE
//   o         - frame result (distance, or N - distance when MODE=1)
//   o_valid   - o is final; o and match are held while this is high
//   match     - o <= thresh; meaningful only while o_valid is high
//   busy      - frame in progress
//   dbg_state - current frame state (0 IDLE, 1 ACCUM, 2 DONE)
//
// Handshake: a beat transfers on a rising edge where in_valid and in_ready
// are both high. Cycles with in_valid low are bubbles with no limit on their
// number. in_valid outside ACCUM is ignored and no data is absorbed.
//
// N must be divisible by CC. CC=1 and W=1 are both legal.

module hamming_stream_acc #(
    parameter int N    = 32,
    parameter int CC   = 8,
    parameter int MODE = 0,
    localparam int W   = N / CC,
    localparam int OW  = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  g_input,
    input  logic [W-1:0]  e_input,
    input  logic [OW-1:0] thresh,
    output logic [OW-1:0] o,
    output logic          o_valid,
    output logic          match,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    localparam int PW = $clog2(W + 1);   // per-beat popcount width
    localparam int CW = $clog2(CC + 1);  // beat counter width

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] o_q, o_d;
    logic          match_q, match_d;

    logic          beat_fire;
    logic [PW-1:0] beat_pc;
    logic [OW-1:0] acc_sum;
    logic [OW-1:0] result;

    function automatic logic [PW-1:0] popcount(input logic [W-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        o_d       = o_q;
        match_d   = match_q;
        beat_fire = in_valid && (state_q == S_ACCUM);
        beat_pc   = popcount(g_input ^ e_input);
        // acc never exceeds N, which fits in OW bits, so no overflow.
        acc_sum   = acc_q + OW'(beat_pc);
        result    = (MODE != 0) ? (OW'(N) - acc_sum) : acc_sum;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_ACCUM: begin
                // start is ignored here; a coincident beat is still taken.
                if (beat_fire) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(CC - 1)) begin
                        // Result and compare are captured on the same edge
                        // that takes the last beat, so they are stable for
                        // the whole DONE residency.
                        state_d = S_DONE;
                        o_d     = result;
                        match_d = (result <= thresh);
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    o_d     = '0;
                    match_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            o_q     <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            match_q <= match_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign busy      = (state_q == S_ACCUM);
    assign o_valid   = (state_q == S_DONE);
    assign o         = o_q;
    assign match     = match_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hamming_stream_acc.sv
module tb_hamming_stream_acc;

    localparam int N  = 32;
    localparam int CC = 8;
    localparam int W  = N / CC;
    localparam int OW = $clog2(N + 1);
    localparam int EW = 2 * OW + 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [W-1:0]  g_input;
    logic [W-1:0]  e_input;
    logic [OW-1:0] thresh;

    logic          in_ready0, in_ready1;
    logic [OW-1:0] o0, o1;
    logic          o_valid0, o_valid1;
    logic          match0, match1;
    logic          busy0, busy1;
    logic [1:0]    dbg0, dbg1;

    int tests;
    int fails;
    int cur_dist;

    // Expected entry layout: {o_mode0, o_mode1, match_mode0, match_mode1}
    logic [EW-1:0] exp_q[$];

    hamming_stream_acc #(.N(N), .CC(CC), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready0), .g_input(g_input), .e_input(e_input),
        .thresh(thresh), .o(o0), .o_valid(o_valid0), .match(match0),
        .busy(busy0), .dbg_state(dbg0)
    );

    hamming_stream_acc #(.N(N), .CC(CC), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready1), .g_input(g_input), .e_input(e_input),
        .thresh(thresh), .o(o1), .o_valid(o_valid1), .match(match1),
        .busy(busy1), .dbg_state(dbg1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks: inputs change 1 time unit after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [W-1:0] g, input logic [W-1:0] e);
        logic [W-1:0] x;
        in_valid = 1'b1;
        g_input  = g;
        e_input  = e;
        x        = g ^ e;
        cur_dist = cur_dist + $countones(x);
        step();
        in_valid = 1'b0;
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        g_input  = W'($urandom_range(0, (1 << W) - 1));
        e_input  = W'($urandom_range(0, (1 << W) - 1));
        step();
    endtask

    task automatic push_expected();
        int sim;
        logic [OW-1:0] eo0, eo1;
        sim = N - cur_dist;
        eo0 = OW'(cur_dist);
        eo1 = OW'(sim);
        exp_q.push_back({eo0, eo1, (cur_dist <= int'(thresh)), (sim <= int'(thresh))});
    endtask

    // scoreboard: pop the oldest expected result and compare both modes
    task automatic scoreboard_pop(input string name);
        logic [EW-1:0] e;
        tests++;
        if (o_valid0 !== 1'b1 || o_valid1 !== 1'b1) begin
            fails++;
            $display("FAIL %s o_valid: got %b/%b want 1/1", name, o_valid0, o_valid1);
        end
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s scoreboard: result with no expected entry", name);
            return;
        end
        e = exp_q.pop_front();
        tests++;
        if (o0 !== e[EW-1 -: OW]) begin
            fails++;
            $display("FAIL %s o mode0: got %0d want %0d", name, o0, e[EW-1 -: OW]);
        end
        tests++;
        if (o1 !== e[EW-OW-1 -: OW]) begin
            fails++;
            $display("FAIL %s o mode1: got %0d want %0d", name, o1, e[EW-OW-1 -: OW]);
        end
        tests++;
        if (match0 !== e[1]) begin
            fails++;
            $display("FAIL %s match mode0: got %b want %b", name, match0, e[1]);
        end
        tests++;
        if (match1 !== e[0]) begin
            fails++;
            $display("FAIL %s match mode1: got %b want %b", name, match1, e[0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        tests++;
        if ({o0, o_valid0, match0, busy0, in_ready0} !== '0 ||
            {o1, o_valid1, match1, busy1, in_ready1} !== '0) begin
            fails++;
            $display("FAIL reset outputs: got o=%0d/%0d ov=%b/%b m=%b/%b busy=%b/%b rdy=%b/%b want all 0",
                     o0, o1, o_valid0, o_valid1, match0, match1, busy0, busy1, in_ready0, in_ready1);
        end
        tests++;
        if (dbg0 !== 2'd0) begin
            fails++;
            $display("FAIL reset state: got %0d want 0", dbg0);
        end
        rst = 1'b1;
        step();
        // in_valid in IDLE must not start anything
        send_beat(4'hF, 4'h0);
        tests++;
        if (busy0 !== 1'b0 || o_valid0 !== 1'b0) begin
            fails++;
            $display("FAIL idle_in_valid: got busy=%b ov=%b want 0/0", busy0, o_valid0);
        end
    endtask

    task automatic test_equal();
        thresh   = '0;
        pulse_start();
        cur_dist = 0;
        for (int i = 0; i < CC; i++) begin
            send_beat(4'h3, 4'h3);
            if (i == CC - 2) begin
                tests++;
                if (o_valid0 !== 1'b0) begin
                    fails++;
                    $display("FAIL equal early_valid: got %b want 0", o_valid0);
                end
            end
        end
        push_expected();
        scoreboard_pop("equal");
    endtask

    task automatic test_all_ones();
        thresh = '0;
        pulse_start();
        cur_dist = 0;
        for (int i = 0; i < CC; i++) send_beat(4'hF, 4'h0);
        push_expected();
        scoreboard_pop("all_ones");
    endtask

    task automatic test_bubbles();
        thresh = 6'd10;
        pulse_start();
        cur_dist = 0;
        for (int i = 0; i < CC; i++) begin
            send_beat(4'h1, 4'h0);
            if (i == 1 || i == 3 || i == 5) begin
                bubble();
                tests++;
                if (in_ready0 !== 1'b1 || busy0 !== 1'b1 || o_valid0 !== 1'b0) begin
                    fails++;
                    $display("FAIL bubble beat%0d: got rdy=%b busy=%b ov=%b want 1/1/0",
                             i, in_ready0, busy0, o_valid0);
                end
            end
        end
        push_expected();
        scoreboard_pop("bubbles");
    endtask

    task automatic test_thresh();
        thresh = 6'd8;
        pulse_start();
        cur_dist = 0;
        for (int i = 0; i < CC; i++) send_beat(4'h1, 4'h0);
        push_expected();
        scoreboard_pop("thresh_eq");
        thresh = 6'd7;
        pulse_start();
        cur_dist = 0;
        for (int i = 0; i < CC; i++) send_beat(4'h8, 4'h0);
        push_expected();
        scoreboard_pop("thresh_lt");
        // thresh moving during DONE must not disturb the held compare
        thresh = 6'd31;
        step();
        step();
        tests++;
        if (match0 !== 1'b0 || o0 !== 6'd8 || o_valid0 !== 1'b1) begin
            fails++;
            $display("FAIL thresh_hold: got m=%b o=%0d ov=%b want 0/8/1", match0, o0, o_valid0);
        end
    endtask

    task automatic test_reset_mid();
        thresh = 6'd20;
        pulse_start();
        cur_dist = 0;
        for (int i = 0; i < 3; i++) send_beat(4'hF, 4'h0);
        rst = 1'b0;
        step();
        tests++;
        if (o0 !== '0 || o_valid0 !== 1'b0 || busy0 !== 1'b0 || in_ready0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: got o=%0d ov=%b busy=%b rdy=%b want 0/0/0/0",
                     o0, o_valid0, busy0, in_ready0);
        end
        rst = 1'b1;
        step();
        pulse_start();
        cur_dist = 0;
        for (int i = 0; i < CC; i++) send_beat(4'hF, 4'h0);
        push_expected();
        scoreboard_pop("after_abort");
    endtask

    task automatic test_start_mid();
        logic [OW-1:0] held;
        thresh = 6'd16;
        pulse_start();
        cur_dist = 0;
        for (int i = 0; i < CC; i++) begin
            if (i == 3) start = 1'b1;
            if (i < 4) send_beat(4'hF, 4'h0);
            else send_beat(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
            start = 1'b0;
        end
        push_expected();
        scoreboard_pop("start_mid");
        held = OW'(cur_dist);
        // beats offered during DONE must be dropped
        send_beat(4'hF, 4'h0);
        send_beat(4'hF, 4'h0);
        tests++;
        if (o_valid0 !== 1'b1 || in_ready0 !== 1'b0 || o0 !== held) begin
            fails++;
            $display("FAIL done_in_valid: got ov=%b rdy=%b o=%0d want 1/0/%0d",
                     o_valid0, in_ready0, o0, held);
        end
        pulse_start();
        tests++;
        if (o_valid0 !== 1'b0 || busy0 !== 1'b1) begin
            fails++;
            $display("FAIL done_restart: got ov=%b busy=%b want 0/1", o_valid0, busy0);
        end
        cur_dist = 0;
        for (int i = 0; i < CC; i++) send_beat(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        push_expected();
        scoreboard_pop("restart_frame");
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 6; f++) begin
            thresh = OW'($urandom_range(0, N));
            pulse_start();
            cur_dist = 0;
            for (int i = 0; i < CC; i++) begin
                while ($urandom_range(0, 3) == 0) bubble();
                send_beat(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
            end
            push_expected();
            scoreboard_pop("back_to_back");
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        cur_dist = 0;
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        g_input  = '0;
        e_input  = '0;
        thresh   = '0;
        test_reset();
        test_equal();
        test_all_ones();
        test_bubbles();
        test_thresh();
        test_reset_mid();
        test_start_mid();
        test_back_to_back();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
